operand_fetch_unit: RTL

OPERAND_FETCH_UNIT -- requirements
Module: operand_fetch_unit

---
 rtl/operand_fetch_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/operand_fetch_unit.sv
// operand_fetch_unit: 6502-style operand and indirect-pointer fetch sequencer.
// Define JMP_IND_PAGE_BUG_EN for the NMOS JMP (ind) pointer-hi page wrap.
module operand_fetch_unit (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [3:0]  addr_mode,
   input  logic [15:0] PC_in,
   input  logic [7:0]  X_reg,
   input  logic [7:0]  Y_reg,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ready,
   output logic        busy,
   output logic        done,
   output logic [7:0]  operand_lo,
   output logic [7:0]  operand_hi,
   output logic [15:0] ptr_addr,
   output logic        page_crossed,
   output logic [15:0] pc_next
);
   typedef enum logic [2:0] {IDLE, OP_LO, OP_HI, PTR_LO, PTR_HI, FINISH} state_t;
   localparam logic [3:0] M_IND = 4'd7, M_INDX = 4'd8, M_INDY = 4'd9;
   state_t      state;
   logic        req;
   logic [3:0]  mode_q;
   logic [15:0] pc_q;
   logic [7:0]  x_q, y_q, ptr_lo;
   logic [1:0]  n_in, n_q;
   logic [15:0] ptr_full, ptr_y, ptr_hi_addr;
   function automatic logic [1:0] op_bytes(input logic [3:0] m);
      return (m <= 4'd3 || m == 4'd8 || m == 4'd9 || m == 4'd10) ? 2'd1 : (m <= 4'd7) ? 2'd2 : 2'd0;
   endfunction
   always_comb begin
      n_in = op_bytes(addr_mode);
      n_q = op_bytes(mode_q);
      ptr_full = {mem_rdata, ptr_lo};
      ptr_y = ptr_full + {8'h00, y_q};
`ifdef JMP_IND_PAGE_BUG_EN
      ptr_hi_addr = (mode_q == M_IND) ? {mem_addr[15:8], mem_addr[7:0] + 8'd1} : {8'h00, mem_addr[7:0] + 8'd1};
`else
      ptr_hi_addr = (mode_q == M_IND) ? mem_addr + 16'd1 : {8'h00, mem_addr[7:0] + 8'd1};
`endif
   end
   // start is latched in IDLE; the sequence begins one cycle later, giving the 2-cycle overhead
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         req <= 1'b0;
         mode_q <= 4'd0;
         pc_q <= 16'd0;
         x_q <= 8'd0;
         y_q <= 8'd0;
         ptr_lo <= 8'd0;
         mem_addr <= 16'd0;
         mem_rd <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         operand_lo <= 8'd0;
         operand_hi <= 8'd0;
         ptr_addr <= 16'd0;
         page_crossed <= 1'b0;
         pc_next <= 16'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  req <= 1'b0;
                  if (n_q == 2'd0) begin
                     state <= FINISH;
                     done <= 1'b1;
                  end else begin
                     state <= OP_LO;
                     mem_rd <= 1'b1;
                     mem_addr <= pc_q + 16'd1;
                  end
               end else if (start) begin
                  req <= 1'b1;
                  busy <= 1'b1;
                  mode_q <= addr_mode;
                  pc_q <= PC_in;
                  x_q <= X_reg;
                  y_q <= Y_reg;
                  operand_lo <= 8'd0;
                  operand_hi <= 8'd0;
                  ptr_addr <= 16'd0;
                  page_crossed <= 1'b0;
                  pc_next <= PC_in + 16'd1 + {14'd0, n_in};
               end
            end
            OP_LO: begin
               if (mem_ready) begin
                  operand_lo <= mem_rdata;
                  if (n_q == 2'd2) begin
                     state <= OP_HI;
                     mem_addr <= pc_q + 16'd2;
                  end else if (mode_q == M_INDX || mode_q == M_INDY) begin
                     state <= PTR_LO;
                     mem_addr <= {8'h00, (mode_q == M_INDX) ? mem_rdata + x_q : mem_rdata};
                  end else begin
                     state <= FINISH;
                     mem_rd <= 1'b0;
                     mem_addr <= 16'd0;
                     done <= 1'b1;
                  end
               end
            end
            OP_HI: begin
               if (mem_ready) begin
                  operand_hi <= mem_rdata;
                  if (mode_q == M_IND) begin
                     state <= PTR_LO;
                     mem_addr <= {mem_rdata, operand_lo};
                  end else begin
                     state <= FINISH;
                     mem_rd <= 1'b0;
                     mem_addr <= 16'd0;
                     done <= 1'b1;
                  end
               end
            end
            PTR_LO: begin
               if (mem_ready) begin
                  ptr_lo <= mem_rdata;
                  state <= PTR_HI;
                  mem_addr <= ptr_hi_addr;
               end
            end
            PTR_HI: begin
               if (mem_ready) begin
                  ptr_addr <= (mode_q == M_INDY) ? ptr_y : ptr_full;
                  page_crossed <= (mode_q == M_INDY) && (ptr_y[15:8] != mem_rdata);
                  state <= FINISH;
                  mem_rd <= 1'b0;
                  mem_addr <= 16'd0;
                  done <= 1'b1;
               end
            end
            FINISH: begin
               done <= 1'b0;
               busy <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
